// File: rtl/heichips25_tiny_host_pkg.sv
// Shared opcodes, FSM states and response codes for the tiny-project host driver.
package heichips25_tiny_host_pkg;

  typedef enum logic [7:0] {
    OP_WR_UI  = 8'h01,
    OP_WR_UIO = 8'h02,
    OP_SEL    = 8'h03,
    OP_RESET  = 8'h04,
    OP_STEP   = 8'h05,
    OP_RD_UO  = 8'h06,
    OP_RD_UIO = 8'h07
  } op_e;

  typedef enum logic [2:0] {
    S_OP,
    S_ARG,
    S_EXEC,
    S_RST,
    S_WAIT,
    S_RSP0,
    S_RSP1
  } state_e;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

endpackage

// File: rtl/heichips25_tiny_host_if.sv
// Command/response byte streams between a command source and the tiny-project host.
interface heichips25_tiny_host_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;

  modport master (
    output cmd_data, cmd_valid, rsp_ready,
    input  cmd_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  cmd_data, cmd_valid, rsp_ready,
    output cmd_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/heichips25_tiny_host.sv
// Byte-command host driving a tiny-project pin bundle; returns sampled outputs as responses.
// Define HEICHIPS25_TINY_HOST_ACK_EN to make every write/reset/step return an 8'hA5 byte.
module heichips25_tiny_host
  import heichips25_tiny_host_pkg::*;
#(
  parameter logic [7:0] UI_RESET  = 8'h00,
  parameter logic       ENA_RESET = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  heichips25_tiny_host_if.slave        bus,
  output logic [7:0]                   dut_ui_in,
  output logic [7:0]                   dut_uio_in,
  output logic                         dut_ena,
  output logic                         dut_rst_n,
  input  logic [7:0]                   dut_uo_out,
  input  logic [7:0]                   dut_uio_out,
  input  logic [7:0]                   dut_uio_oe
);

`ifdef HEICHIPS25_TINY_HOST_ACK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] arg_q, arg_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cap_oe_q, cap_oe_d;
  logic [7:0] rsp_q, rsp_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic [7:0] ui_q, ui_d;
  logic [7:0] uio_q, uio_d;
  logic       ena_q, ena_d;
  logic       rst_n_q, rst_n_d;
  logic       hs;
  logic       done;

  assign hs = bus.cmd_valid && cmd_ready_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    cap_oe_d    = cap_oe_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    ui_d        = ui_q;
    uio_d       = uio_q;
    ena_d       = ena_q;
    rst_n_d     = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      S_OP: if (hs) begin
        op_d    = bus.cmd_data;
        state_d = S_ARG;
      end
      S_ARG: if (hs) begin
        arg_d   = bus.cmd_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_OP;
        case (op_q)
          OP_WR_UI:  begin ui_d  = arg_q;    done = 1'b1; end
          OP_WR_UIO: begin uio_d = arg_q;    done = 1'b1; end
          OP_SEL:    begin ena_d = arg_q[0]; done = 1'b1; end
          OP_RESET: begin
            rst_n_d = 1'b0;
            cnt_d   = arg_q;
            state_d = S_RST;
          end
          OP_STEP: begin
            if (arg_q == 8'd0) begin
              done = 1'b1;
            end else begin
              cnt_d   = arg_q - 8'd1;
              state_d = S_WAIT;
            end
          end
          OP_RD_UO: begin
            rsp_d       = dut_uo_out;
            rsp_valid_d = 1'b1;
            state_d     = S_RSP0;
          end
          OP_RD_UIO: begin
            rsp_d       = dut_uio_out;
            cap_oe_d    = dut_uio_oe;
            rsp_valid_d = 1'b1;
            state_d     = S_RSP0;
          end
          default: begin
            rsp_d       = RSP_ERR;
            rsp_valid_d = 1'b1;
            state_d     = S_RSP0;
          end
        endcase
      end
      // cnt counts remaining extra low cycles; release when it hits zero
      S_RST: begin
        if (cnt_q == 8'd0) begin
          state_d = S_OP;
          done    = 1'b1;
        end else begin
          rst_n_d = 1'b0;
          cnt_d   = cnt_q - 8'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_OP;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RSP0: if (bus.rsp_ready) begin
        if (op_q == OP_RD_UIO) begin
          rsp_d   = cap_oe_q;
          state_d = S_RSP1;
        end else begin
          rsp_valid_d = 1'b0;
          state_d     = S_OP;
        end
      end
      S_RSP1: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = S_OP;
      end
      default: state_d = S_OP;
    endcase

    if (AckEn && done) begin
      rsp_d       = RSP_ACK;
      rsp_valid_d = 1'b1;
      state_d     = S_RSP0;
    end

    cmd_ready_d = (state_d == S_OP) || (state_d == S_ARG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OP;
      op_q        <= 8'h00;
      arg_q       <= 8'h00;
      cnt_q       <= 8'h00;
      cap_oe_q    <= 8'h00;
      rsp_q       <= 8'h00;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      ui_q        <= UI_RESET;
      uio_q       <= 8'h00;
      ena_q       <= ENA_RESET;
      rst_n_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      cnt_q       <= cnt_d;
      cap_oe_q    <= cap_oe_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      ena_q       <= ena_d;
      rst_n_q     <= rst_n_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_data  = rsp_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign dut_ui_in     = ui_q;
  assign dut_uio_in    = uio_q;
  assign dut_ena       = ena_q;
  assign dut_rst_n     = rst_n_q;

endmodule
